// File: rtl/tfacc_cpu_regs_if.sv
// CPU data bus between the sr_cpu core (or its BFM) and a responder.
// One word per access, no wait states.
interface tfacc_cpu_regs_if;
  logic [31:0] adr;
  logic        we;
  logic        re;
  logic        rdy;
  logic [31:0] dw;
  logic [31:0] dr;

  modport master (
    output adr, we, re, dw,
    input  rdy, dr
  );

  modport slave (
    input  adr, we, re, dw,
    output rdy, dr
  );
endinterface

// File: rtl/tfacc_cpu_regs.sv
// tfacc control/status/parameter registers on the CPU data bus.
// Start pulse, busy/done tracking, busy-cycle counter, level irq.
module tfacc_cpu_regs #(
  parameter logic [31:0] BASE   = 32'h0000_8000,
  parameter int          NPARAM = 4,
  parameter logic [31:0] ID     = 32'h7FAC_0001
) (
  input  logic                     clk,
  input  logic                     xreset,
  tfacc_cpu_regs_if.slave          bus,
  output logic                     start,
  output logic                     busy,
  input  logic                     done_in,
  output logic [32*NPARAM-1:0]     param,
  output logic                     irq
);

  logic [NPARAM-1:0][31:0] prm;
  logic [31:0] cycles;
  logic [31:0] rdata;
  logic [31:0] dr_q;
  logic        rdy_q;
  logic        done;
  logic        irq_en;
  logic        sel;
  logic        wr;
  logic        rd;
  logic [5:0]  idx;
  logic        go;
  logic        fin;

  assign sel = bus.adr[31:8] == BASE[31:8];
  assign idx = bus.adr[7:2];
  assign wr  = bus.we & sel;
  assign rd  = bus.re & sel;
  // busy blocks a new start, so a held CTRL write cannot retrigger
  assign go  = wr && idx == 6'd0 && bus.dw[0] && !busy;
  assign fin = done_in & busy;

  assign bus.rdy = rdy_q;
  assign bus.dr  = dr_q;
  assign param   = prm;
  assign irq     = done & irq_en;

  // Read mux over the pre-write register values
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      idx == 6'd0: rdata = {30'b0, irq_en, 1'b0};
      idx == 6'd1: rdata = {30'b0, done, busy};
      idx == 6'd2: rdata = cycles;
      idx == 6'd3: rdata = ID;
      default: begin
        for (int k = 0; k < NPARAM; k++)
          if (idx == 6'(k + 4)) rdata = prm[k];
      end
    endcase
  end

  // Bus response: ready after reset, registered read data
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      rdy_q <= 1'b0;
      dr_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (bus.re) dr_q <= sel ? rdata : '0;
    end
  end

  // Control, run state and busy-cycle counter
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      start  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      irq_en <= 1'b0;
      cycles <= '0;
    end else begin
      start <= go;
      if (wr && idx == 6'd0) irq_en <= bus.dw[1];
      if (go) begin
        busy   <= 1'b1;
        done   <= 1'b0;
        cycles <= '0;
      end else begin
        if (busy && cycles != '1) cycles <= cycles + 32'd1;
        // a done set on the same edge wins over the clear
        if (fin) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else if (wr && idx == 6'd1 && bus.dw[1]) begin
          done <= 1'b0;
        end
      end
    end
  end

  // Parameter registers
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      prm <= '0;
    end else begin
      for (int k = 0; k < NPARAM; k++)
        if (wr && idx == 6'(k + 4)) prm[k] <= bus.dw;
    end
  end

endmodule

// File: tb/tb_tfacc_cpu_regs.sv
// Directed bench for tfacc_cpu_regs.
// Hand-computed expectations, one checker task.
module tb_tfacc_cpu_regs;
  localparam logic [31:0] B = 32'h0000_8000;

  logic         clk = 1'b0;
  logic         xreset = 1'b0;
  logic         start;
  logic         busy;
  logic         done_in = 1'b0;
  logic [127:0] param;
  logic         irq;
  logic [31:0]  rv;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           pulses = 0;
  int           p0;

  tfacc_cpu_regs_if bus();

  tfacc_cpu_regs dut (
    .clk     (clk),
    .xreset  (xreset),
    .bus     (bus),
    .start   (start),
    .busy    (busy),
    .done_in (done_in),
    .param   (param),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start) pulses <= pulses + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus.adr = a;
    bus.dw  = d;
    bus.we  = 1'b1;
    @(posedge clk);
    #1 bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    bus.adr = a;
    bus.re  = 1'b1;
    @(posedge clk);
    #1 bus.re = 1'b0;
    d = bus.dr;
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    @(posedge clk);
    #1 done_in = 1'b0;
  endtask

  initial begin
    bus.adr = '0;
    bus.dw  = '0;
    bus.we  = 1'b0;
    bus.re  = 1'b0;
    #23;
    chk("rst_rdy", 32'(bus.rdy), 0);
    chk("rst_dr", bus.dr, 0);
    xreset = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy", 32'(bus.rdy), 1);
    chk("rst_out", {busy, start, irq}, 0);
    chk("rst_param", param[31:0] | param[127:96], 0);
    rd(B + 32'h0C, rv);
    chk("id", rv, 32'h7FAC_0001);

    // params
    wr(B + 32'h10, 32'hDEAD_BEEF);
    chk("param0_out", param[31:0], 32'hDEAD_BEEF);
    wr(B + 32'h1C, 32'h1234_5678);
    chk("param3_out", param[127:96], 32'h1234_5678);
    rd(B + 32'h10, rv);
    chk("param0_rd", rv, 32'hDEAD_BEEF);
    rd(B + 32'h1C, rv);
    chk("param3_rd", rv, 32'h1234_5678);
    rd(B + 32'h80, rv);
    chk("hole_rd", rv, 0);
    wr(32'h0000_9010, 32'h5555_5555);
    chk("outside_wr", param[31:0], 32'hDEAD_BEEF);
    rd(B + 32'h0C, rv);
    rd(32'h0000_900C, rv);
    chk("outside_rd", rv, 0);
    // simultaneous read and write returns the old value
    bus.adr = B + 32'h14;
    bus.dw  = 32'hCAFE_0001;
    bus.we  = 1'b1;
    bus.re  = 1'b1;
    @(posedge clk);
    #1 bus.we = 1'b0;
    bus.re = 1'b0;
    chk("rw_old", bus.dr, 0);
    chk("rw_new", param[63:32], 32'hCAFE_0001);

    // run with done 10 edges after start rose
    p0 = pulses;
    wr(B + 32'h00, 32'h3);
    chk("start_hi", {start, busy}, 32'h3);
    @(posedge clk);
    #1 chk("start_lo", {start, busy}, 32'h1);
    repeat (8) @(posedge clk);
    #1 pulse_done();
    chk("run_end", {busy, irq}, 32'h1);
    rd(B + 32'h04, rv);
    chk("status", rv, 2);
    rd(B + 32'h08, rv);
    chk("cycles10", rv, 10);
    rd(B + 32'h00, rv);
    chk("ctrl_rd", rv, 2);
    chk("pulse1", pulses - p0, 1);
    wr(B + 32'h04, 32'h2);
    chk("irq_clr", 32'(irq), 0);

    // held start write
    p0 = pulses;
    bus.adr = B;
    bus.dw  = 32'h1;
    bus.we  = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.we = 1'b0;
    @(posedge clk);
    #1 chk("held_pulses", pulses - p0, 1);
    chk("held_busy", 32'(busy), 1);
    pulse_done();

    // STATUS clear colliding with done_in
    wr(B, 32'h3);
    repeat (2) @(posedge clk);
    #1 bus.adr = B + 32'h04;
    bus.dw = 32'h2;
    bus.we = 1'b1;
    done_in = 1'b1;
    @(posedge clk);
    #1 bus.we = 1'b0;
    done_in = 1'b0;
    rd(B + 32'h04, rv);
    chk("clr_vs_done", rv, 2);
    chk("irq_kept", 32'(irq), 1);

    // start write colliding with done_in
    wr(B + 32'h04, 32'h2);
    p0 = pulses;
    wr(B, 32'h1);
    repeat (2) @(posedge clk);
    #1 bus.adr = B;
    bus.dw = 32'h1;
    bus.we = 1'b1;
    done_in = 1'b1;
    @(posedge clk);
    #1 bus.we = 1'b0;
    done_in = 1'b0;
    @(posedge clk);
    #1 chk("coll_pulses", pulses - p0, 1);
    rd(B + 32'h04, rv);
    chk("coll_status", rv, 2);
    rd(B + 32'h08, rv);
    chk("coll_cycles", rv, 3);

    // reset in the middle of a run
    wr(B, 32'h3);
    repeat (3) @(posedge clk);
    #3 xreset = 1'b0;
    #1;
    chk("mr_busy", {busy, start, irq, bus.rdy}, 0);
    chk("mr_param", param[31:0] | param[63:32], 0);
    @(posedge clk);
    #2 xreset = 1'b1;
    @(posedge clk);
    #1 rd(B + 32'h08, rv);
    chk("mr_cycles", rv, 0);
    rd(B + 32'h04, rv);
    chk("mr_status", rv, 0);
    wr(B, 32'h1);
    repeat (2) @(posedge clk);
    #1 pulse_done();
    rd(B + 32'h08, rv);
    chk("mr_rerun", rv, 3);
    chk("mr_irq", 32'(irq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
